// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
//   Key-schedule and block-gating controller for AES-128/192/256.
//   A key arrives in one (128) or two (192/256) 128-bit beats. It is expanded
//   one 32-bit word per cycle, and each completed 128-bit round key is
//   broadcast with a one-hot per-round write strobe. While a schedule is in
//   progress, block traffic between the input FIFO and the round pipeline is
//   held off.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   key_valid/key_ready   key beat handshake; key_data word order is [127:96] first
//   key_mode              00=128, 01=192, 10=256, 11=illegal (first beat only)
//   mode_err              one-cycle pulse after a rejected first beat
//   rk_data, rk_we        round key and one-hot round strobe (bit r = round key r)
//   nr                    round count of the active schedule
//   busy                  schedule in progress
//   blk_*_in / blk_*_out  block pass-through, gated by busy
//
// aes_sbox
//   Byte S-box built as GF(2^8) inversion followed by the affine transform.
//   Ports: in_i (input byte), out_o (substituted byte).

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      else      p = p;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv_s;

  // Inversion followed by the affine transform
  always_comb begin
    inv_s = gf_inv(in_i);
    out_o = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
                  ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
  end

endmodule

module aes_key_sched_ctrl #(
  parameter int NR_MAX      = 14,
  parameter bit SUPPORT_256 = 1'b1,
  parameter int BLK_W       = 130
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [127:0]      key_data,
  input  logic [1:0]        key_mode,
  output logic              mode_err,
  output logic [127:0]      rk_data,
  output logic [NR_MAX:0]   rk_we,
  output logic [3:0]        nr,
  output logic              busy,
  input  logic              blk_valid_in,
  output logic              blk_ready_in,
  input  logic [BLK_W-1:0]  blk_data_in,
  output logic              blk_valid_out,
  input  logic              blk_ready_out,
  output logic [BLK_W-1:0]  blk_data_out
);

  // Sliding window of the most recent words; w[i-Nk] sits at index Nk-1
  localparam int NW = SUPPORT_256 ? 8 : 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD2  = 2'd1,
    ST_EXPAND = 2'd2
  } state_e;

  // Next round constant: multiply by x in GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      nkm1_q, nkm1_d;        // Nk-1
  logic [3:0]      nr_q, nr_d;
  logic [5:0]      widx_q, widx_d;        // index of the next word to produce
  logic [2:0]      kpos_q, kpos_d;        // widx mod Nk
  logic [7:0]      rcon_q, rcon_d;
  logic [31:0]     win_q [NW];
  logic [31:0]     win_d [NW];
  logic [31:0]     asm_q [4];
  logic [31:0]     asm_d [4];
  logic [127:0]    rk_data_q, rk_data_d;
  logic [NR_MAX:0] rk_we_q, rk_we_d;
  logic            busy_q, busy_d;
  logic            key_ready_q, key_ready_d;
  logic            mode_err_q, mode_err_d;

  logic            key_fire_s;
  logic            mode_ok_s;
  logic [2:0]      mode_nkm1_s;
  logic [3:0]      mode_nr_s;
  logic [31:0]     prev_s, rot_s, sub_s, t_s, old_word_s, new_word_s;

  // Decode the requested key length from key_mode
  always_comb begin
    mode_ok_s   = 1'b0;
    mode_nkm1_s = 3'd3;
    mode_nr_s   = 4'd10;
    case (key_mode)
      2'b00: begin
        mode_ok_s   = 1'b1;
        mode_nkm1_s = 3'd3;
        mode_nr_s   = 4'd10;
      end
      2'b01: begin
        mode_ok_s   = SUPPORT_256;
        mode_nkm1_s = 3'd5;
        mode_nr_s   = 4'd12;
      end
      2'b10: begin
        mode_ok_s   = SUPPORT_256;
        mode_nkm1_s = 3'd7;
        mode_nr_s   = 4'd14;
      end
      default: begin
        mode_ok_s   = 1'b0;
        mode_nkm1_s = 3'd3;
        mode_nr_s   = 4'd10;
      end
    endcase
  end

  assign prev_s = win_q[0];
  // RotWord is only applied on the Nk boundary; the mid-key SubWord of AES-256 is unrotated
  assign rot_s  = (kpos_q == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_s[8*b +: 8]),
      .out_o (sub_s[8*b +: 8])
    );
  end

  if (SUPPORT_256) begin : g_old8
    assign old_word_s = win_q[nkm1_q];
  end else begin : g_old4
    assign old_word_s = win_q[3];
  end

  // Temporary word t for the current expansion step
  always_comb begin
    t_s = prev_s;
    if (kpos_q == 3'd0) begin
      t_s = sub_s ^ {rcon_q, 24'h000000};
    end else if ((nkm1_q == 3'd7) && (kpos_q == 3'd4)) begin
      t_s = sub_s;
    end else begin
      t_s = prev_s;
    end
  end

  assign new_word_s = old_word_s ^ t_s;
  assign key_fire_s = key_valid & key_ready_q;

  // Next-state, word window, assembly register and round-key strobe
  always_comb begin
    state_d     = state_q;
    nkm1_d      = nkm1_q;
    nr_d        = nr_q;
    widx_d      = widx_q;
    kpos_d      = kpos_q;
    rcon_d      = rcon_q;
    win_d       = win_q;
    asm_d       = asm_q;
    rk_data_d   = rk_data_q;
    rk_we_d     = '0;
    mode_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_fire_s) begin
          if (mode_ok_s) begin
            nkm1_d = mode_nkm1_s;
            nr_d   = mode_nr_s;
            widx_d = 6'd4;
            kpos_d = 3'd0;
            rcon_d = 8'h01;
            for (int k = 4; k < NW; k++) win_d[k] = win_q[k-4];
            win_d[3] = key_data[127:96];
            win_d[2] = key_data[95:64];
            win_d[1] = key_data[63:32];
            win_d[0] = key_data[31:0];
            // w0..w3 arrive together, so round key 0 is complete immediately
            rk_data_d = key_data;
            rk_we_d   = {{NR_MAX{1'b0}}, 1'b1};
            state_d   = (mode_nkm1_s == 3'd3) ? ST_EXPAND : ST_LOAD2;
          end else begin
            mode_err_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD2: begin
        if (key_fire_s) begin
          kpos_d  = 3'd0;
          state_d = ST_EXPAND;
          if (nkm1_q == 3'd7) begin
            for (int k = 4; k < NW; k++) win_d[k] = win_q[k-4];
            win_d[3]  = key_data[127:96];
            win_d[2]  = key_data[95:64];
            win_d[1]  = key_data[63:32];
            win_d[0]  = key_data[31:0];
            widx_d    = 6'd8;
            rk_data_d = key_data;
            rk_we_d   = {{(NR_MAX-1){1'b0}}, 2'b10};
          end else begin
            // 192: only w4,w5; they start round key 1 in the assembly register
            for (int k = 2; k < NW; k++) win_d[k] = win_q[k-2];
            win_d[1] = key_data[127:96];
            win_d[0] = key_data[95:64];
            asm_d[0] = key_data[127:96];
            asm_d[1] = key_data[95:64];
            widx_d   = 6'd6;
          end
        end else begin
          state_d = ST_LOAD2;
        end
      end
      ST_EXPAND: begin
        for (int k = 1; k < NW; k++) win_d[k] = win_q[k-1];
        win_d[0]             = new_word_s;
        asm_d[widx_q[1:0]]   = new_word_s;
        widx_d               = widx_q + 6'd1;
        kpos_d               = (kpos_q == nkm1_q) ? 3'd0 : kpos_q + 3'd1;
        rcon_d               = (kpos_q == 3'd0) ? xtime(rcon_q) : rcon_q;
        if (widx_q[1:0] == 2'd3) begin
          rk_data_d = {asm_q[0], asm_q[1], asm_q[2], new_word_s};
          rk_we_d   = {{NR_MAX{1'b0}}, 1'b1} << widx_q[5:2];
        end else begin
          rk_we_d   = '0;
        end
        if (widx_q == {nr_q, 2'b11}) state_d = ST_IDLE;
        else                         state_d = ST_EXPAND;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d      = (state_d != ST_IDLE);
    key_ready_d = (state_d != ST_EXPAND);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      nkm1_q      <= 3'd3;
      nr_q        <= 4'd10;
      widx_q      <= 6'd0;
      kpos_q      <= 3'd0;
      rcon_q      <= 8'h01;
      for (int k = 0; k < NW; k++) win_q[k] <= 32'h0;
      for (int k = 0; k < 4; k++)  asm_q[k] <= 32'h0;
      rk_data_q   <= 128'h0;
      rk_we_q     <= '0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b1;
      mode_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      nkm1_q      <= nkm1_d;
      nr_q        <= nr_d;
      widx_q      <= widx_d;
      kpos_q      <= kpos_d;
      rcon_q      <= rcon_d;
      win_q       <= win_d;
      asm_q       <= asm_d;
      rk_data_q   <= rk_data_d;
      rk_we_q     <= rk_we_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
      mode_err_q  <= mode_err_d;
    end
  end

  assign key_ready     = key_ready_q;
  assign mode_err      = mode_err_q;
  assign rk_data       = rk_data_q;
  assign rk_we         = rk_we_q;
  assign nr            = nr_q;
  assign busy          = busy_q;
  assign blk_valid_out = blk_valid_in & ~busy_q;
  assign blk_ready_in  = blk_ready_out & ~busy_q;
  assign blk_data_out  = blk_data_in;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;
  localparam int NR_MAX = 14;
  localparam int BLK_W  = 130;

  logic              clk = 1'b0;
  logic              rst;
  logic              key_valid, key_ready, mode_err, busy;
  logic [127:0]      key_data, rk_data;
  logic [1:0]        key_mode;
  logic [NR_MAX:0]   rk_we;
  logic [3:0]        nr;
  logic              blk_valid_in, blk_ready_in, blk_valid_out, blk_ready_out;
  logic [BLK_W-1:0]  blk_data_in, blk_data_out;

  logic              k0_valid, k0_ready, k0_err, k0_busy, k0_bvo, k0_bri;
  logic [127:0]      k0_rk;
  logic [NR_MAX:0]   k0_we;
  logic [3:0]        k0_nr;
  logic [BLK_W-1:0]  k0_bdo;

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.NR_MAX(NR_MAX), .SUPPORT_256(1'b1), .BLK_W(BLK_W)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_data(key_data), .key_mode(key_mode), .mode_err(mode_err),
    .rk_data(rk_data), .rk_we(rk_we), .nr(nr), .busy(busy),
    .blk_valid_in(blk_valid_in), .blk_ready_in(blk_ready_in), .blk_data_in(blk_data_in),
    .blk_valid_out(blk_valid_out), .blk_ready_out(blk_ready_out), .blk_data_out(blk_data_out)
  );

  aes_key_sched_ctrl #(.NR_MAX(NR_MAX), .SUPPORT_256(1'b0), .BLK_W(BLK_W)) dut0 (
    .clk(clk), .rst(rst), .key_valid(k0_valid), .key_ready(k0_ready),
    .key_data(key_data), .key_mode(key_mode), .mode_err(k0_err),
    .rk_data(k0_rk), .rk_we(k0_we), .nr(k0_nr), .busy(k0_busy),
    .blk_valid_in(blk_valid_in), .blk_ready_in(k0_bri), .blk_data_in(blk_data_in),
    .blk_valid_out(k0_bvo), .blk_ready_out(blk_ready_out), .blk_data_out(k0_bdo)
  );

  int n_checks = 0;
  int n_errors = 0;
  int nr_model = 10;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (FIPS-197 key expansion) ----------------
  logic [7:0]   sbox_tab [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0]  wm [60];
  logic [127:0] rk_exp [15];

  // S-box table from the generator walk over GF(2^8) (p runs over 3^k, q = 1/p)
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk, input int nrr);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) wm[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nrr+1); i++) begin
      t = wm[i-1];
      if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h000000};
      else if (nk == 8 && i % nk == 4) t = sub_word(t);
      wm[i] = wm[i-nk] ^ t;
    end
    for (int r = 0; r <= nrr; r++) rk_exp[r] = {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
  endtask

  // Cycle (counted from first-beat acceptance) in which word j becomes known
  function automatic int word_cycle(input int j, input int nk, input int nbeats);
    if (j < 4)  return 0;
    if (j < nk) return 1;
    return nbeats + (j - nk);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_blocks();
    logic [159:0] tmp;
    tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
    blk_data_in   = tmp[BLK_W-1:0];
    blk_valid_in  = ($urandom_range(0, 3) != 0);
    blk_ready_out = ($urandom_range(0, 5) != 0);
  endtask

  // One full schedule with random block traffic; entered and left at posedge+1
  task automatic run_sched(input logic [1:0] mode, input logic [127:0] b1,
                           input logic [127:0] b2, input string nm);
    int nk, nr_e, nbeats, last_cyc, strobes, bad_prof, bad_gate, bad_we, xfer_out, xfer_exp;
    logic [NR_MAX:0] we_exp;
    logic [255:0]    k;
    logic            busy_e, rdy_e;
    nk     = (mode == 2'b00) ? 4 : (mode == 2'b01) ? 6 : 8;
    nr_e   = nk + 6;
    nbeats = (nk == 4) ? 1 : 2;
    k      = (nk == 4) ? {b1, 128'h0} : (nk == 6) ? {b1, b2[127:64], 64'h0} : {b1, b2};
    model_expand(k, nk, nr_e);
    last_cyc = word_cycle(4*nr_e+3, nk, nbeats) + 1;
    strobes = 0; bad_prof = 0; bad_gate = 0; bad_we = 0; xfer_out = 0; xfer_exp = 0;
    for (int cyc = 0; cyc <= last_cyc; cyc++) begin
      if (cyc == 0) begin
        key_valid = 1'b1; key_data = b1; key_mode = mode;
      end else if (cyc < nbeats) begin
        key_valid = 1'b1; key_data = b2; key_mode = 2'($urandom);
      end else if (cyc < last_cyc) begin
        key_valid = 1'($urandom); key_data = rnd128(); key_mode = 2'($urandom);
      end else begin
        key_valid = 1'b0;
      end
      drive_blocks();
      @(negedge clk);
      busy_e = (cyc >= 1) && (cyc < last_cyc);
      rdy_e  = !((cyc >= nbeats) && (cyc < last_cyc));
      if (busy !== busy_e || key_ready !== rdy_e || mode_err !== 1'b0) bad_prof++;
      if (blk_valid_out !== (blk_valid_in & ~busy_e) || blk_ready_in !== (blk_ready_out & ~busy_e)
          || blk_data_out !== blk_data_in) bad_gate++;
      if (blk_valid_in && blk_ready_out && !busy_e) xfer_exp++;
      if (blk_valid_out === 1'b1 && blk_ready_out && blk_ready_in === 1'b1) xfer_out++;
      we_exp = '0;
      for (int r = 0; r <= nr_e; r++)
        if (word_cycle(4*r+3, nk, nbeats) + 1 == cyc) we_exp[r] = 1'b1;
      if (rk_we !== we_exp) bad_we++;
      strobes += $countones(rk_we);
      for (int r = 0; r <= nr_e; r++)
        if (we_exp[r]) check_val($sformatf("%s_rk%0d", nm, r), rk_data, rk_exp[r]);
      @(posedge clk); #1;
    end
    key_valid = 1'b0; blk_valid_in = 1'b0; blk_ready_out = 1'b0;
    check_val({nm, "_busy_ready_profile"}, bad_prof, 0);
    check_val({nm, "_blk_gating"}, bad_gate, 0);
    check_val({nm, "_blk_transfers"}, xfer_out, xfer_exp);
    check_val({nm, "_rk_we_timing"}, bad_we, 0);
    check_val({nm, "_strobe_count"}, strobes, nr_e + 1);
    check_val({nm, "_nr"}, nr, nr_e);
    nr_model = nr_e;
  endtask

  task automatic run_bad(input string nm);
    key_valid = 1'b1; key_mode = 2'b11; key_data = rnd128();
    @(negedge clk);
    check_val({nm, "_consumed"}, key_ready, 1'b1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    @(negedge clk);
    check_val({nm, "_mode_err_pulse"}, mode_err, 1'b1);
    check_val({nm, "_busy"}, busy, 1'b0);
    check_val({nm, "_rk_we"}, rk_we, '0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val({nm, "_mode_err_end"}, mode_err, 1'b0);
    check_val({nm, "_nr_kept"}, nr, nr_model);
    @(posedge clk); #1;
  endtask

  task automatic run_bad_s0(input logic [1:0] mode, input string nm);
    k0_valid = 1'b1; key_mode = mode; key_data = rnd128();
    @(negedge clk);
    @(posedge clk); #1;
    k0_valid = 1'b0;
    @(negedge clk);
    check_val({nm, "_mode_err_pulse"}, k0_err, 1'b1);
    check_val({nm, "_busy"}, k0_busy, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val({nm, "_mode_err_end"}, k0_err, 1'b0);
    check_val({nm, "_nr_kept"}, k0_nr, 4'd10);
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    bit found;
    build_sbox();
    rst = 1'b1; key_valid = 1'b0; k0_valid = 1'b0; key_data = '0; key_mode = 2'b00;
    blk_valid_in = 1'b0; blk_ready_out = 1'b0; blk_data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_key_ready", key_ready, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_rk_we", rk_we, '0);
    check_val("rst_rk_data", rk_data, 128'h0);
    check_val("rst_nr", nr, 4'd10);
    check_val("rst_mode_err", mode_err, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_sched(2'b00, K128, 128'h0, "a128");
    check_val("a128_rk10_vec", rk_data, RK10);
    run_sched(2'b01, 128'h8e73b0f7da0e6452c810f32b809079e5,
              {64'h62f8ead2522c6b7b, $urandom, $urandom}, "a192");
    check_val("a192_rk12_vec", rk_data, 128'he98ba06f448c773c8ecc720401002202);
    run_sched(2'b10, 128'h603deb1015ca71be2b73aef0857d7781,
              128'h1f352c073b6108d72d9810a30914dff4, "a256");
    check_val("a256_rk14_vec", rk_data, 128'hfe4890d1e6188d0b046df344706c631e);

    run_bad("bad11");
    run_bad_s0(2'b10, "s0_m10");
    run_bad_s0(2'b01, "s0_m01");

    // Reduced instance still runs AES-128 and gates blocks while busy
    k0_valid = 1'b1; key_mode = 2'b00; key_data = K128;
    blk_valid_in = 1'b1; blk_ready_out = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    k0_valid = 1'b0;
    @(negedge clk);
    check_val("s0_rk0_we", k0_we, 15'h0001);
    check_val("s0_rk0", k0_rk, K128);
    check_val("s0_gate", {k0_bvo, k0_bri}, 2'b00);
    check_val("s0_data", k0_bdo, blk_data_in);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k0_we[10] === 1'b1) found = 1'b1;
    end
    check_val("s0_rk10_seen", found, 1'b1);
    check_val("s0_rk10", k0_rk, RK10);
    check_val("s0_busy_low", k0_busy, 1'b0);
    @(posedge clk); #1;
    blk_valid_in = 1'b0; blk_ready_out = 1'b0;

    // Asynchronous reset while word 20 of an AES-256 schedule is produced
    key_valid = 1'b1; key_mode = 2'b10; key_data = rnd128();
    @(posedge clk); #1;
    key_data = rnd128();
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    check_val("arst_mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_val("arst_key_ready", key_ready, 1'b1);
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_rk_we", rk_we, '0);
    check_val("arst_rk_data", rk_data, 128'h0);
    check_val("arst_nr", nr, 4'd10);
    @(negedge clk);
    rst = 1'b0;
    nr_model = 10;
    @(posedge clk); #1;
    run_sched(2'b00, K128, 128'h0, "post_rst");
    check_val("post_rst_rk10_vec", rk_data, RK10);

    for (int n = 0; n < 6; n++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 2));
      run_sched(m, rnd128(), rnd128(), $sformatf("rnd%0d_m%0d", n, m));
    end
    run_bad("bad11_late");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Successor to the fixed AES-128 controller: a parametrised key-schedule and data-gating controller for AES-128, AES-192 and AES-256.
- Accepts a key in one or two 128-bit beats and expands it one 32-bit word per cycle.
- Broadcasts each 128-bit round key to the round pipeline with a one-hot per-round write strobe.
- Sits between the input FIFO and the round pipeline, and stalls block traffic while a schedule is in progress.

Parameters:
- NR_MAX, 14: highest round index supported; the write strobe is NR_MAX+1 bits wide.
- SUPPORT_256, 1: when 0, modes 192 and 256 are rejected and the word buffer shrinks to 4 words.
- BLK_W, 130: width of the pass-through block payload (data plus metadata).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- key_valid  in  1  key beat valid
- key_ready  out  1  key beat accepted when key_valid&key_ready
- key_data  in  128  key beat; word order is [127:96] first (FIPS-197 w0)
- key_mode  in  2  00=128, 01=192, 10=256, 11=illegal; sampled on the first beat only
- mode_err  out  1  one-cycle pulse when a first beat is rejected
- rk_data  out  128  round key, {w[4r],w[4r+1],w[4r+2],w[4r+3]}
- rk_we  out  NR_MAX+1  one-hot strobe; bit r means rk_data is round key r
- nr  out  4  round count of the active schedule (10/12/14)
- busy  out  1  schedule in progress
- blk_valid_in  in  1  block from FIFO
- blk_ready_in  out  1  FIFO pop
- blk_data_in  in  BLK_W  block payload
- blk_valid_out  out  1  block to round pipeline
- blk_ready_out  in  1  pipeline ready
- blk_data_out  out  BLK_W  payload, passed through combinationally

Behaviour:
- Reset values: state=IDLE, key_ready=1, busy=0, rk_we=0, rk_data=0, nr=10, mode_err=0, word buffer cleared.
- Reset is asynchronous and takes effect mid-schedule. The partial schedule is abandoned; the round pipeline keeps its stale keys until the next full schedule.
- Nk (key length in words) = 4/6/8 and Nr = 10/12/14 for mode 00/01/10.
- States:
  - IDLE: key_ready=1, busy=0. Accepting a beat with legal mode latches Nk/Nr, loads w0..w3 and goes to LOAD2 (Nk>4) or EXPAND (Nk=4).
  - Illegal mode, or mode 01/10 with SUPPORT_256=0: the beat is consumed, mode_err pulses the next cycle, the state stays IDLE and nr is unchanged.
  - LOAD2: key_ready=1, busy=1. The accepted beat loads w4,w5 from [127:64] (192; [63:0] ignored) or w4..w7 (256). key_mode is ignored in this state. Next state is EXPAND.
  - EXPAND: key_ready=0, busy=1. Produces one word w[i] per cycle: w[i]=w[i-Nk]^t with t=w[i-1].
    - If i%Nk==0: t=SubWord(RotWord(t))^Rcon[i/Nk], with Rcon = 01,02,04,08,10,20,40,80,1b,36 in the top byte.
    - If Nk==8 and i%Nk==4: t=SubWord(t).
    - SubWord uses four instances of the team's byte S-box. Word index i is a 6-bit counter.
    - Exit to IDLE after word 4*(Nr+1)-1 is produced: 40/46/52 EXPAND cycles.
- A new key while busy is not possible: key_ready is low in EXPAND. In LOAD2 the beat is always treated as the second half of the current key.
- Round key emission:
  - Every word, loaded or generated, enters a 4-word assembly register.
  - The cycle after a group of 4 completes, rk_data holds that group and rk_we has exactly bit r set. Otherwise rk_we=0 and rk_data holds its last value.
  - Indices are strictly ascending 0..Nr; exactly Nr+1 strobes per schedule.
  - Bits above Nr are never asserted.
- Loaded beats can complete groups: 128 gives rk0 the cycle after beat 1; 256 gives rk0 after beat 1 and rk1 after beat 2. For 192, rk1 completes on the 2nd generated word.
- busy falls in the same cycle rk_we[Nr] is asserted. nr updates on first-beat acceptance.
- Block gating (combinational):
  - blk_valid_out = blk_valid_in & ~busy
  - blk_ready_in = blk_ready_out & ~busy
  - blk_data_out = blk_data_in
  - No block pops while busy. Blocks flow in the cycle busy is low, including the cycle of rk_we[Nr].
- key_valid and a block arriving in the same IDLE cycle: the key is accepted. The block also passes that cycle because busy is still 0; busy rises the next cycle.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, one beat -> rk_we[0] one cycle later with rk_data=key; rk_we[10] with d014f9a8c9ee2589e13f0cc8b6630ca6 41 cycles after acceptance; nr=10; 11 strobes total.
- AES-192, beats 8e73b0f7da0e6452c810f32b809079e5 and 62f8ead2522c6b7b_xxxxxxxxxxxxxxxx -> 13 ascending strobes; rk12=e98ba06f448c773c8ecc720401002202; nr=12.
- AES-256, beats 603deb1015ca71be2b73aef0857d7781 and 1f352c073b6108d72d9810a30914dff4 -> rk1 equals beat 2 one cycle after it; rk14=fe4890d1e6188d0b046df344706c631e; no rk_we bit set above 14.
- Blocks streaming with blk_ready_out=1, then a key issued -> no blk_ready_in/blk_valid_out while busy; streaming resumes in the rk_we[Nr] cycle; no block is lost or duplicated.
- key_mode=11 -> mode_err pulses once, busy stays 0, nr unchanged. Repeat with SUPPORT_256=0 and mode 10 -> same result.
- rst asserted at word 20 of an AES-256 schedule -> outputs reach reset values asynchronously; a following AES-128 schedule produces correct keys.
